regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file: configurable width/depth, two combinational read ports, one write port.
- Adds write-to-read bypass and a per-register pending (scoreboard) bit.
- Sits between decode (reads, destination reservation) and writeback (result write) so the pipeline can stall on RAW hazards against long-latency producers (loads, multi-cycle ALU ops).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, >= 2.
- AW, 5, address width; must equal log2(NREGS).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never becomes pending.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all registers and pending bits
- rs1_addr  in  AW  read port 1 address
- rs2_addr  in  AW  read port 2 address
- rs1_data  out  XLEN  read port 1 data
- rs2_data  out  XLEN  read port 2 data
- rs1_busy  out  1  register addressed by port 1 is pending
- rs2_busy  out  1  register addressed by port 2 is pending
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- res_valid  in  1  reserve (mark pending) register res_addr
- res_addr  in  AW  register to reserve
- flush  in  1  clear all pending bits (pipeline squash)
- waw_hazard  out  1  res_valid to an already-pending register this cycle
- pending_cnt  out  AW+1  number of pending registers

Behaviour:
- Reset (reset low, asynchronous): all registers = 0, all pending bits = 0, pending_cnt = 0. While low, the read ports return 0 and busy/waw_hazard = 0.
- Reads are combinational, zero latency. Per port, in priority order:
  - ZERO_REG=1 and addr==0 -> data 0, busy 0.
  - Otherwise, BYPASS=1 and we and wa==addr (write enabled and legal) -> data = wd, busy 0.
  - Otherwise -> data = stored value, busy = pending[addr].
- BYPASS=0: reads return the stored value; the new value is visible from the cycle after the write edge.
- Write (rising edge): if we, and not (ZERO_REG and wa==0): reg[wa] <= wd and pending[wa] <= 0. A write to a non-pending register is legal and simply updates it.
- Reserve (rising edge): if res_valid, and not (ZERO_REG and res_addr==0): pending[res_addr] <= 1.
- Same-edge write and reserve:
  - Same address: data is written and the register stays pending (the new producer wins).
  - Different addresses: both take effect.
- Flush (rising edge): every pending bit <= 0. This overrides any reserve in the same cycle. A write in the same cycle still updates register data.
- waw_hazard = res_valid and pending[res_addr] and the register is not reserved-exempt (ZERO_REG and addr 0), and not cleared by a same-cycle we to that address. Combinational and informational only; the reservation still takes effect.
- pending_cnt is registered: the population count of the pending bits after each edge. Range 0..NREGS, or 0..NREGS-1 when ZERO_REG=1.
- Reset asserted mid-operation aborts everything immediately. The first edge after release behaves as from a clean state.
- Out-of-range addresses are impossible (AW = log2 NREGS); no wrap handling is needed.

Test Plan:
- Reset low, then release; read all addresses -> every rs*_data = 0, rs*_busy = 0, pending_cnt = 0.
- we=1, wa=5, wd=0xDEADBEEF, rs1_addr=5 in the same cycle -> rs1_data = 0xDEADBEEF combinationally (BYPASS=1); next cycle with we=0 still 0xDEADBEEF.
- we=1, wa=0, wd=0x1234; res_valid=1, res_addr=0 -> rs1_addr=0 reads 0 with busy 0; pending_cnt stays 0.
- Reserve r7; next cycle rs2_addr=7 -> rs2_busy=1, pending_cnt=1. Reserve r7 again -> waw_hazard=1. Then we r7 = 0x55 with res_valid on r7 in the same cycle -> data 0x55 and still busy. Write r7 = 0x66 alone -> busy 0, pending_cnt 0.
- Reserve r3, r4, r9 on successive cycles (pending_cnt=3). Then flush together with res_valid on r10 -> all busy 0, pending_cnt 0.
- Write r12 = 0xA5A5A5A5, reserve r12, pulse reset low mid-cycle -> immediately rs*_data 0 and busy 0. After release, r12 reads 0 and pending_cnt = 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port,
// write-to-read bypass and a per-register pending (scoreboard) bit used by
// decode to stall on RAW hazards against long-latency producers.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  // Read ports
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,

  // Write port (writeback)
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i,

  // Destination reservation (decode)
  input  logic            res_valid_i,
  input  logic [AW-1:0]   res_addr_i,

  // Pipeline squash
  input  logic            flush_i,

  // Status
  output logic            waw_hazard_o,
  output logic [AW:0]     pending_cnt_o
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic write_ok;
  logic res_ok;

  // Writes and reservations to a hard-wired zero register are dropped.
  always_comb begin
    write_ok = we_i;
    res_ok   = res_valid_i;
    if (ZERO_REG) begin
      if (wa_i == '0)       write_ok = 1'b0;
      if (res_addr_i == '0) res_ok   = 1'b0;
    end
  end

  // Next-state register data: only the addressed entry changes on a write.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (write_ok) begin
      regs_d[wa_i] = wd_i;
    end
  end

  // Next-state pending bits. Reserve is applied after the write clear so a
  // same-address write+reserve leaves the register pending (new producer wins);
  // flush then overrides everything.
  always_comb begin
    pend_d = pend_q;
    if (write_ok) begin
      pend_d[wa_i] = 1'b0;
    end
    if (res_ok) begin
      pend_d[res_addr_i] = 1'b1;
    end
    if (flush_i) begin
      pend_d = '0;
    end
  end

  // Population count of the next pending vector, registered alongside it.
  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
    end
  end

  // Register array state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Scoreboard state and its registered population count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read port 1: zero register, then bypass, then stored value. Forced to
  // zero while reset is held so bypassed write data cannot leak out.
  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    rs1_busy_o = pend_q[rs1_addr_i];
    if (!rst_ni) begin
      rs1_data_o = '0;
      rs1_busy_o = 1'b0;
    end else if (ZERO_REG && (rs1_addr_i == '0)) begin
      rs1_data_o = '0;
      rs1_busy_o = 1'b0;
    end else if (BYPASS && write_ok && (wa_i == rs1_addr_i)) begin
      rs1_data_o = wd_i;
      rs1_busy_o = 1'b0;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rs2_data_o = regs_q[rs2_addr_i];
    rs2_busy_o = pend_q[rs2_addr_i];
    if (!rst_ni) begin
      rs2_data_o = '0;
      rs2_busy_o = 1'b0;
    end else if (ZERO_REG && (rs2_addr_i == '0)) begin
      rs2_data_o = '0;
      rs2_busy_o = 1'b0;
    end else if (BYPASS && write_ok && (wa_i == rs2_addr_i)) begin
      rs2_data_o = wd_i;
      rs2_busy_o = 1'b0;
    end
  end

  // WAW flag: reserving a register whose outstanding producer has not
  // written back, unless that write lands this very cycle.
  always_comb begin
    waw_hazard_o = 1'b0;
    if (rst_ni && res_ok && pend_q[res_addr_i]) begin
      waw_hazard_o = !(write_ok && (wa_i == res_addr_i));
    end
  end

  assign pending_cnt_o = cnt_q;

endmodule
